// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin sharing of one simple-bus target port
// between N_REQ requesters, one bus cycle and one ack pulse per grant.
module simple_bus_arbiter #(
   parameter int N_REQ = 2,
   parameter int GID_W = $clog2(N_REQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    m_req,
   input  logic [N_REQ-1:0]    m_we,
   input  logic [N_REQ*8-1:0]  m_addr,
   input  logic [N_REQ*32-1:0] m_wdata,
   output logic [N_REQ-1:0]    m_ack,
   output logic [31:0]         m_rdata,
   output logic                bus_wr,
   output logic                bus_rd,
   output logic [7:0]          bus_addr,
   output logic [31:0]         bus_wdata,
   input  logic [31:0]         bus_rdata,
   output logic                busy,
   output logic [GID_W-1:0]    grant_id,
   output logic [15:0]         xfer_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [GID_W-1:0]   last_q, last_d;
   logic [GID_W-1:0]   grant_id_q, grant_id_d;
   logic               we_q, we_d;
   logic               bus_wr_q, bus_wr_d;
   logic               bus_rd_q, bus_rd_d;
   logic [7:0]         bus_addr_q, bus_addr_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;
   logic [N_REQ-1:0]   m_ack_q, m_ack_d;
   logic               busy_q, busy_d;
   logic [15:0]        xfer_count_q, xfer_count_d;

   logic               win_found;
   logic [GID_W-1:0]   win_idx;
   logic [GID_W-1:0]   cand;

   // Round-robin search starting just after the last winner
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = GID_W'((int'(last_q) + i) % N_REQ);
         if (!win_found && m_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= GID_W'(N_REQ - 1);
         grant_id_q   <= '0;
         we_q         <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_rd_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         m_ack_q      <= '0;
         busy_q       <= 1'b0;
         xfer_count_q <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         grant_id_q   <= grant_id_d;
         we_q         <= we_d;
         bus_wr_q     <= bus_wr_d;
         bus_rd_q     <= bus_rd_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         m_ack_q      <= m_ack_d;
         busy_q       <= busy_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   // Next state: grant from IDLE, then one BUS cycle and one RESP cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_found) state_d = BUS;
         BUS:     state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs computed for the state being entered
   always_comb begin
      last_d       = last_q;
      grant_id_d   = grant_id_q;
      we_d         = we_q;
      bus_wr_d     = 1'b0;
      bus_rd_d     = 1'b0;
      bus_addr_d   = '0;
      bus_wdata_d  = '0;
      m_ack_d      = '0;
      busy_d       = 1'b0;
      xfer_count_d = xfer_count_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_id_d = win_idx;
               we_d       = m_we[win_idx];
               bus_wr_d   = m_we[win_idx];
               bus_rd_d   = !m_we[win_idx];
               bus_addr_d = m_addr[8*win_idx +: 8];
               if (m_we[win_idx])
                  bus_wdata_d = m_wdata[32*win_idx +: 32];
               busy_d     = 1'b1;
            end
         end
         BUS: begin
            m_ack_d = N_REQ'(1) << grant_id_q;
            busy_d  = 1'b1;
         end
         RESP: begin
            last_d       = grant_id_q;
            xfer_count_d = xfer_count_q + 16'd1;
         end
         default: ;
      endcase
   end

   assign m_rdata    = (state_q == RESP && !we_q) ? bus_rdata : 32'd0;
   assign m_ack      = m_ack_q;
   assign bus_wr     = bus_wr_q;
   assign bus_rd     = bus_rd_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign busy       = busy_q;
   assign grant_id   = grant_id_q;
   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: vector table, directed corner sequences and
// random traffic against a transaction-level round-robin model.
module tb_simple_bus_arbiter;

   localparam int N  = 2;
   localparam int GW = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_we;
   logic [N*8-1:0]  m_addr;
   logic [N*32-1:0] m_wdata;
   logic [N-1:0]    m_ack;
   logic [31:0]     m_rdata;
   logic            bus_wr;
   logic            bus_rd;
   logic [7:0]      bus_addr;
   logic [31:0]     bus_wdata;
   logic [31:0]     bus_rdata;
   logic            busy;
   logic [GW-1:0]   grant_id;
   logic [15:0]     xfer_count;

   logic            tgt_reload;
   logic [31:0]     mem [256];
   logic [31:0]     ref_mem [256];

   int checks   = 0;
   int failures = 0;

   simple_bus_arbiter #(.N_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m_req      (m_req),
      .m_we       (m_we),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_ack      (m_ack),
      .m_rdata    (m_rdata),
      .bus_wr     (bus_wr),
      .bus_rd     (bus_rd),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .busy       (busy),
      .grant_id   (grant_id),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      if (a == 4) return 32'h1234_5678;
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // Behavioural target: registered read data, write on strobe
   always @(posedge clk) begin
      if (tgt_reload) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(i);
         bus_rdata <= 32'd0;
      end else begin
         if (bus_wr) mem[bus_addr] <= bus_wdata;
         if (bus_rd) bus_rdata <= mem[bus_addr];
      end
   end

   typedef logic [93:0] snap_t;

   function automatic snap_t mk(input logic wr, input logic rd,
                                input logic [7:0] a, input logic [31:0] wd,
                                input logic [1:0] ack, input logic [31:0] rdd,
                                input logic b, input logic [GW-1:0] gid,
                                input logic [15:0] cnt);
      return {wr, rd, a, wd, ack, rdd, b, gid, cnt};
   endfunction

   function automatic snap_t snap();
      return {bus_wr, bus_rd, bus_addr, bus_wdata, m_ack, m_rdata,
              busy, grant_id, xfer_count};
   endfunction

   task automatic chk(input string nm, input snap_t act, input snap_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields(input int i);
      m_we[i]            = 1'($urandom_range(1));
      m_addr[8*i +: 8]   = 8'($urandom);
      m_wdata[32*i +: 32] = $urandom;
   endtask

   function automatic int rr(input int last, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [7:0]  a0;
      logic [7:0]  a1;
      logic [31:0] d0;
      snap_t       exp;
   } vec_t;

   vec_t tbl [15];

   initial begin
      int acks [N];
      int order [$];
      int when [$];
      int e, g, w, last_m, gid_m, max_wait;
      int waitc [N];
      logic        mwe;
      logic [7:0]  maddr;
      logic [31:0] mwd, mrd;
      logic [15:0] cnt_m;
      logic [N-1:0]    s_req, s_we;
      logic [N*8-1:0]  s_addr;
      logic [N*32-1:0] s_wd;
      bit gaps_ok;

      tbl[0]  = '{2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF,
                  mk(1, 0, 8'h10, 32'hDEADBEEF, 2'b00, 0, 1, 0, 0)};
      tbl[1]  = '{2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF,
                  mk(0, 0, 0, 0, 2'b01, 0, 1, 0, 0)};
      tbl[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 1)};
      tbl[3]  = '{2'b10, 2'b00, 8'h00, 8'h04, 32'h0,
                  mk(0, 1, 8'h04, 0, 2'b00, 0, 1, 1, 1)};
      tbl[4]  = '{2'b10, 2'b00, 8'h00, 8'h04, 32'h0,
                  mk(0, 0, 0, 0, 2'b10, 32'h12345678, 1, 1, 1)};
      tbl[5]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 2)};
      tbl[6]  = '{2'b01, 2'b00, 8'h20, 8'h00, 32'h0,
                  mk(0, 1, 8'h20, 0, 2'b00, 0, 1, 0, 2)};
      tbl[7]  = '{2'b01, 2'b00, 8'h30, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b01, 32'hC0DE0020, 1, 0, 2)};
      tbl[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 3)};
      tbl[9]  = '{2'b01, 2'b01, 8'h44, 8'h00, 32'h55,
                  mk(1, 0, 8'h44, 32'h55, 2'b00, 0, 1, 0, 3)};
      tbl[10] = '{2'b01, 2'b01, 8'h44, 8'h00, 32'h55,
                  mk(0, 0, 0, 0, 2'b01, 0, 1, 0, 3)};
      tbl[11] = '{2'b01, 2'b01, 8'h44, 8'h00, 32'h55,
                  mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 4)};
      tbl[12] = '{2'b01, 2'b01, 8'h44, 8'h00, 32'h55,
                  mk(1, 0, 8'h44, 32'h55, 2'b00, 0, 1, 0, 4)};
      tbl[13] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b01, 0, 1, 0, 4)};
      tbl[14] = '{2'b00, 2'b00, 8'h00, 8'h00, 32'h0,
                  mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 5)};

      rst_n = 1'b0; tgt_reload = 1'b1;
      m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
      tick(); tick();
      chk("reset", snap(), '0);
      rst_n = 1'b1; tgt_reload = 1'b0;

      for (int k = 0; k < 15; k++) begin
         m_req   = tbl[k].req;
         m_we    = tbl[k].we;
         m_addr  = {tbl[k].a1, tbl[k].a0};
         m_wdata = {32'h1111_1111, tbl[k].d0};
         tick();
         chk($sformatf("vec%0d", k), snap(), tbl[k].exp);
      end

      // Reset while the read strobe is on the bus
      m_req = 2'b01; m_we = 2'b00; m_addr = {8'h0C, 8'h08};
      tick();
      chk("rst_bus_pre", snap(), mk(0, 1, 8'h08, 0, 0, 0, 1, 0, 5));
      rst_n = 1'b0;
      tick();
      chk("rst_bus_clear", snap(), '0);
      rst_n = 1'b1; m_req = 2'b11;
      tick();
      chk("rst_release_grant", snap(), mk(0, 1, 8'h08, 0, 0, 0, 1, 0, 0));
      tick();
      chk("rst_release_ack", snap(),
          mk(0, 0, 0, 0, 2'b01, 32'hC0DE0008, 1, 0, 0));
      m_req = 2'b10;
      tick();
      chk("rst_after_idle", snap(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();
      chk("rst_next_req1", snap(), mk(0, 1, 8'h0C, 0, 0, 0, 1, 1, 1));
      m_req = 2'b00;
      tick(); tick();

      // Contention: both hold requests for four transactions each
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      m_req = 2'b11; m_we = 2'b11;
      m_addr = {8'h60, 8'h50}; m_wdata = {32'hAAAA_0001, 32'h5555_0000};
      acks[0] = 0; acks[1] = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus_wr || bus_rd) begin
            order.push_back(int'(grant_id));
            when.push_back(c);
         end
         for (int i = 0; i < N; i++)
            if (m_ack[i]) begin
               acks[i]++;
               if (acks[i] == 4) m_req[i] = 1'b0;
            end
      end
      chk("cont_count", snap_t'(order.size()), snap_t'(8));
      for (int k = 0; k < order.size() && k < 8; k++)
         chk($sformatf("cont_order%0d", k), snap_t'(order[k]),
             snap_t'(k % 2));
      gaps_ok = 1'b1;
      for (int k = 1; k < when.size(); k++)
         if (when[k] - when[k-1] != 3) gaps_ok = 1'b0;
      chk("cont_spacing", snap_t'(gaps_ok), snap_t'(1));
      chk("cont_xfer", snap_t'(xfer_count), snap_t'(8));

      // Counter wrap from 0xFFFF
      force dut.xfer_count_q = 16'hFFFF;
      tick();
      release dut.xfer_count_q;
      chk("wrap_pre", snap_t'(xfer_count), snap_t'(16'hFFFF));
      m_req = 2'b01; m_we = 2'b01; m_addr = {8'h00, 8'h70};
      tick(); tick();
      m_req = 2'b00;
      tick();
      chk("wrap_post", snap_t'(xfer_count), snap_t'(16'h0000));

      // Random traffic against a transaction-level model
      rst_n = 1'b0; tgt_reload = 1'b1; m_req = '0;
      tick();
      rst_n = 1'b1; tgt_reload = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      e = 0; g = -100; w = 0; last_m = N - 1; gid_m = 0; cnt_m = 0;
      mwe = 1'b0; maddr = '0; mwd = '0; mrd = '0; max_wait = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int c = 0; c < 1500; c++) begin
         s_req = m_req; s_we = m_we; s_addr = m_addr; s_wd = m_wdata;
         tick();
         e++;
         if (e - g >= 3 && s_req != '0) begin
            w      = rr(last_m, s_req);
            g      = e;
            last_m = w;
            gid_m  = w;
            mwe    = s_we[w];
            maddr  = s_addr[8*w +: 8];
            mwd    = mwe ? s_wd[32*w +: 32] : 32'd0;
            mrd    = mwe ? 32'd0 : ref_mem[maddr];
            if (mwe) ref_mem[maddr] = mwd;
         end
         if (e == g + 2) cnt_m = cnt_m + 16'd1;
         chk("random", snap(),
             mk(e == g && mwe, e == g && !mwe,
                (e == g) ? maddr : 8'h00, (e == g) ? mwd : 32'd0,
                (e == g + 1) ? 2'(1 << w) : 2'b00,
                (e == g + 1) ? mrd : 32'd0,
                (e == g) || (e == g + 1), GW'(gid_m), cnt_m));
         for (int i = 0; i < N; i++) begin
            if (e == g && w == i) waitc[i] = 0;
            else if (s_req[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > max_wait) max_wait = waitc[i];
         end
         for (int i = 0; i < N; i++) begin
            if (e == g + 1 && w == i) begin
               if ($urandom_range(1) == 0) m_req[i] = 1'b0;
               else begin
                  m_req[i] = 1'b1;
                  rand_fields(i);
               end
            end else if (e == g && w == i) begin
               rand_fields(i);
               if ($urandom_range(3) == 0) m_req[i] = 1'b0;
            end else if (!m_req[i] && $urandom_range(2) == 0) begin
               m_req[i] = 1'b1;
               rand_fields(i);
            end
         end
      end
      chk("starvation_bound", snap_t'(max_wait <= 3 * N), snap_t'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
